alu_cu_dmem: RTL and testbench
==============================

# alu_cu_dmem

Execution-side datapath block of the 5-stage RV32I pipeline. It bundles three cooperating units:
- a combinational control decoder that turns decoded instruction fields into pipeline control signals (ID stage);
- a 32-bit ALU with zero/negative flags (EX stage);
- a word-organised data memory with combinational read and synchronous write (MEM stage).

Byte/half masking, forwarding and PC selection are handled outside this block.

## Interface
- DMEM_DEPTH, 1024, data memory size in 32-bit words (power of two)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cu_info  in  17  [6:0] opcode, [9:7] funct3, [16:10] funct7
- nop  in  1  forces a bubble decode
- we_reg  out  1  register-file write enable
- we_mem  out  1  store enable
- rf_sel  out  3  writeback source: 000 ALU, 001 load, 010 U-imm, 011 PC+4, 100 PC+U-imm
- alu_sel  out  4  ALU op for the decoded instruction
- op2_sel  out  2  operand-2 source: 00 I-imm, 01 S-imm, 10 J-imm, 11 rs2
- is_load  out  1  load instruction
- is_signed  out  1  signed compare / sign-extending load
- word_length  out  2  00 byte, 01 half, 10 word
- op1, op2  in  32  ALU operands
- alu_op  in  4  ALU operation (EX-stage copy of alu_sel)
- alu_signed  in  1  EX-stage copy of is_signed
- alu_out  out  32  ALU result
- z  out  1  alu_out == 0
- n  out  1  less-than flag
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data
- mem_we  in  1  write strobe
- mem_rdata  out  32  read data

## Operation
- **ALU encodings:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
  - 5 SLL, 6 SRL, 7 SRA, with shift amount op2[4:0];
  - 8 SLT, 9 SLTU, giving 32'd1 or 32'd0;
  - 10 PASS op2;
  - 11–15 give 0.
- **ALU arithmetic:** modulo 2^32.
- **z flag:** (alu_out == 0).
- **n flag:**
  - for SUB: signed op1<op2 when alu_signed=1, unsigned op1<op2 when alu_signed=0;
  - otherwise: alu_out[31].
- **Decoder, OP (0110011):**
  - we_reg=1, op2_sel=11, rf_sel=000;
  - funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND;
  - funct7[5] turns ADD into SUB and SRL into SRA;
  - is_signed=1 only for SLT.
- **Decoder, OP-IMM (0010011):**
  - as OP, but op2_sel=00;
  - funct7[5] applies only to shifts;
  - is_signed=1 only for SLTI.
- **Decoder, LOAD (0000011):**
  - ADD, op2_sel=00, rf_sel=001, we_reg=1, is_load=1;
  - word_length=funct3[1:0], is_signed=~funct3[2].
- **Decoder, STORE (0100011):**
  - ADD, op2_sel=01, we_mem=1, word_length=funct3[1:0].
- **Decoder, BRANCH (1100011):**
  - SUB, op2_sel=11, we_reg=0;
  - is_signed=1 for funct3 000/001/100/101, 0 for 110/111.
- **Decoder, LUI (0110111):** rf_sel=010, we_reg=1.
- **Decoder, AUIPC (0010111):** rf_sel=100, we_reg=1.
- **Decoder, JAL (1101111):** ADD, op2_sel=10, rf_sel=011, we_reg=1.
- **Decoder, JALR (1100111):** ADD, op2_sel=00, rf_sel=011, we_reg=1.
- **Decoder defaults:** unlisted outputs are 0. Unknown opcode, nop=1 or rst=1 forces all decoder outputs to 0 (bubble; alu_sel=0, op2_sel=00, word_length=00).
- **Data memory addressing:** word index = mem_addr[log2(DMEM_DEPTH)+1:2]. Upper bits are ignored (wrap-around) and mem_addr[1:0] is ignored.
- **Data memory writes:** always a full 32-bit word. Sub-word masking is external.
- **Memory init:** contents are zero at time 0. rst does not clear memory contents.

## Timing
- Decoder and ALU are purely combinational: zero latency, no state.
- mem_rdata is combinational from mem_addr and the current contents.
- Write occurs at posedge clk when mem_we=1 and rst=0.
- Read-during-write to the same word returns the old value until the edge and the new value after it.
- mem_we asserted during rst is ignored.
- Reset values: decoder outputs 0 while rst=1. alu_out/z/n and mem_rdata follow their inputs and have no reset.

## Configuration
- DMEM_VIDEO_GUARD_EN defined: writes with mem_addr >= 32'h0000_8000 are suppressed and memory stays unchanged, because that region is video memory handled outside.
- Undefined: every write is performed, with index wrap-around.

## Test plan
- **Signed/unsigned SUB flags:** op1=5, op2=7, alu_op=SUB, alu_signed=1 -> alu_out=32'hFFFF_FFFE, z=0, n=1. Same operands with op1=32'hFFFF_FFFF, alu_signed=0 -> n=0.
- **Shifts:** SRA op1=32'h8000_0000, op2=4 -> 32'hF800_0000. SRL with the same operands -> 32'h0800_0000. SLL op1=1, op2=33 -> 2.
- **Decode:**
  - cu_info for LBU (opcode 0000011, funct3 100) -> we_reg=1, is_load=1, rf_sel=001, op2_sel=00, word_length=00, is_signed=0;
  - same cu_info with nop=1 -> all outputs 0;
  - SUB (funct7 0100000) -> alu_sel=1.
- **Branch decode:** BLTU -> alu_sel=SUB, op2_sel=11, is_signed=0, we_reg=0. BGE -> is_signed=1.
- **Memory:**
  - write 32'hDEAD_BEEF at 0x40 -> mem_rdata at 0x40 and 0x43 equals 32'hDEAD_BEEF after the edge;
  - write during rst -> unchanged;
  - with DMEM_DEPTH=1024, address 0x1040 aliases to 0x40.
- **Video guard:** with DMEM_VIDEO_GUARD_EN, a write to 0x8000 leaves word 0 unchanged. Without the macro, word 0 is written.

Source files
------------

// File: rtl/alu_cu_dmem_if.sv
// Data-memory bus between the MEM stage and the alu_cu_dmem block.
// master: pipeline side driving address/data/strobe; slave: the memory.
interface alu_cu_dmem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/alu_cu_dmem.sv
// Execution-side datapath of the 5-stage RV32I pipeline:
// control decoder (ID), 32-bit ALU with z/n flags (EX) and a word-organised
// data memory with combinational read and synchronous write (MEM).
// Optional build macro DMEM_VIDEO_GUARD_EN: suppresses writes at byte
// addresses >= 32'h0000_8000 (video region handled outside this block).
module alu_cu_dmem #(
  parameter int unsigned DMEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16:0]          cu_info,
  input  logic                 nop,
  output logic                 we_reg,
  output logic                 we_mem,
  output logic [2:0]           rf_sel,
  output logic [3:0]           alu_sel,
  output logic [1:0]           op2_sel,
  output logic                 is_load,
  output logic                 is_signed,
  output logic [1:0]           word_length,
  input  logic [31:0]          op1,
  input  logic [31:0]          op2,
  input  logic [3:0]           alu_op,
  input  logic                 alu_signed,
  output logic [31:0]          alu_out,
  output logic                 z,
  output logic                 n,
  alu_cu_dmem_if.slave         dmem
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_b5;

  assign opcode = cu_info[6:0];
  assign funct3 = cu_info[9:7];
  assign f7_b5  = cu_info[15];

  // Register and immediate arithmetic share one funct3 map; funct7[5]
  // selects SUB only for register ops, SRA for both.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic b5,
                                          input logic is_reg);
    case (f3)
      3'b000:  arith_op = (is_reg && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // Control decode; reset, nop and unknown opcodes all yield a bubble.
  always_comb begin
    we_reg      = 1'b0;
    we_mem      = 1'b0;
    rf_sel      = 3'b000;
    alu_sel     = ALU_ADD;
    op2_sel     = 2'b00;
    is_load     = 1'b0;
    is_signed   = 1'b0;
    word_length = 2'b00;
    if (!rst && !nop) begin
      case (opcode)
        OPC_OP: begin
          we_reg    = 1'b1;
          op2_sel   = 2'b11;
          alu_sel   = arith_op(funct3, f7_b5, 1'b1);
          is_signed = (funct3 == 3'b010);
        end
        OPC_OPIMM: begin
          we_reg    = 1'b1;
          alu_sel   = arith_op(funct3, f7_b5, 1'b0);
          is_signed = (funct3 == 3'b010);
        end
        OPC_LOAD: begin
          we_reg      = 1'b1;
          rf_sel      = 3'b001;
          is_load     = 1'b1;
          word_length = funct3[1:0];
          is_signed   = ~funct3[2];
        end
        OPC_STORE: begin
          we_mem      = 1'b1;
          op2_sel     = 2'b01;
          word_length = funct3[1:0];
        end
        OPC_BRANCH: begin
          alu_sel   = ALU_SUB;
          op2_sel   = 2'b11;
          is_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        OPC_LUI: begin
          we_reg = 1'b1;
          rf_sel = 3'b010;
        end
        OPC_AUIPC: begin
          we_reg = 1'b1;
          rf_sel = 3'b100;
        end
        OPC_JAL: begin
          we_reg  = 1'b1;
          op2_sel = 2'b10;
          rf_sel  = 3'b011;
        end
        OPC_JALR: begin
          we_reg = 1'b1;
          rf_sel = 3'b011;
        end
        default: ;
      endcase
    end
  end

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = op2[4:0];
  assign lt_s  = $signed(op1) < $signed(op2);
  assign lt_u  = op1 < op2;

  // ALU result; reserved encodings produce zero.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = op1 + op2;
      ALU_SUB:  alu_out = op1 - op2;
      ALU_AND:  alu_out = op1 & op2;
      ALU_OR:   alu_out = op1 | op2;
      ALU_XOR:  alu_out = op1 ^ op2;
      ALU_SLL:  alu_out = op1 << shamt;
      ALU_SRL:  alu_out = op1 >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(op1) >>> shamt);
      ALU_SLT:  alu_out = {31'b0, lt_s};
      ALU_SLTU: alu_out = {31'b0, lt_u};
      ALU_PASS: alu_out = op2;
      default:  alu_out = '0;
    endcase
  end

  // Flags: for SUB, n is the true less-than so branches need no extra compare.
  always_comb begin
    z = (alu_out == '0);
    n = (alu_op == ALU_SUB) ? (alu_signed ? lt_s : lt_u) : alu_out[31];
  end

  localparam int unsigned IW = $clog2(DMEM_DEPTH);

  logic [31:0]   mem [DMEM_DEPTH] = '{default: '0};
  logic [IW-1:0] word_idx;
  logic          wr_ok;
  logic          unused_bits;

  assign word_idx = dmem.mem_addr[IW+1:2];

`ifdef DMEM_VIDEO_GUARD_EN
  assign wr_ok = dmem.mem_we && (dmem.mem_addr < 32'h0000_8000);
`else
  assign wr_ok = dmem.mem_we;
`endif

  assign unused_bits = &{1'b0, dmem.mem_addr[31:IW+2], dmem.mem_addr[1:0],
                         cu_info[16], cu_info[14:10]};

  // Full-word synchronous write; reset blocks the strobe but never clears data.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[word_idx] <= dmem.mem_wdata;
  end

  assign dmem.mem_rdata = mem[word_idx];

endmodule

// File: tb/tb_alu_cu_dmem.sv
// Scoreboard bench for alu_cu_dmem: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_alu_cu_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] cu_info;
  logic        nop;
  logic        we_reg, we_mem, is_load, is_signed;
  logic [2:0]  rf_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  op2_sel, word_length;
  logic [31:0] op1, op2, alu_out;
  logic [3:0]  alu_op;
  logic        alu_signed, z, n;

  alu_cu_dmem_if bus ();

  alu_cu_dmem #(.DMEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .cu_info(cu_info), .nop(nop),
    .we_reg(we_reg), .we_mem(we_mem), .rf_sel(rf_sel), .alu_sel(alu_sel),
    .op2_sel(op2_sel), .is_load(is_load), .is_signed(is_signed),
    .word_length(word_length), .op1(op1), .op2(op2), .alu_op(alu_op),
    .alu_signed(alu_signed), .alu_out(alu_out), .z(z), .n(n), .dmem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0 alu {out,z,n}, 1 decoder, 2 mem_rdata
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] dec(input logic wr, input logic wm,
      input logic [2:0] rf, input logic [3:0] as, input logic [1:0] o2,
      input logic ld, input logic sg, input logic [1:0] wl);
    dec = {49'b0, wr, wm, rf, as, o2, ld, sg, wl};
  endfunction

  // Monitor: outputs are combinational, so everything pending is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = {30'b0, alu_out, z, n};
        1:       act = {49'b0, we_reg, we_mem, rf_sel, alu_sel, op2_sel,
                        is_load, is_signed, word_length};
        default: act = {32'b0, bus.mem_rdata};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_alu(input string nm, input logic [31:0] o,
                         input logic ez, input logic en);
    exp_t e;
    e.name = nm; e.kind = 0; e.exp = {30'b0, o, ez, en};
    sb.push_back(e);
  endtask

  task automatic exp_dec(input string nm, input logic [63:0] v);
    exp_t e;
    e.name = nm; e.kind = 1; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input string nm, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.kind = 2; e.exp = {32'b0, v};
    sb.push_back(e);
  endtask

  task automatic alu_vec(input string nm, input logic [3:0] op,
      input logic sg, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] o, input logic ez, input logic en);
    step();
    alu_op = op; alu_signed = sg; op1 = a; op2 = b;
    exp_alu(nm, o, ez, en);
  endtask

  task automatic dec_vec(input string nm, input logic [16:0] ci,
                         input logic np, input logic [63:0] v);
    step();
    cu_info = ci; nop = np;
    exp_dec(nm, v);
  endtask

  // Write cycle: old data is expected before the edge, the edge commits.
  task automatic mem_write(input string nm, input logic [31:0] a,
      input logic [31:0] d, input logic in_rst, input logic [31:0] old);
    step();
    bus.mem_addr = a; bus.mem_wdata = d; bus.mem_we = 1'b1; rst = in_rst;
    exp_mem(nm, old);
    step();
    bus.mem_we = 1'b0; rst = 1'b0;
  endtask

  task automatic mem_read(input string nm, input logic [31:0] a,
                          input logic [31:0] v);
    step();
    bus.mem_addr = a;
    exp_mem(nm, v);
  endtask

  initial begin
    rst = 1'b1; nop = 1'b0;
    cu_info = {7'b0, 3'b000, 7'b0110011};
    op1 = '0; op2 = '0; alu_op = '0; alu_signed = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_we = 1'b0;

    step();
    exp_dec("reset_decode", '0);
    exp_mem("reset_mem_zero", 32'h0);
    step();
    rst = 1'b0;

    alu_vec("sub_signed", 4'd1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
    alu_vec("sub_unsigned", 4'd1, 1'b0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF8, 1'b0, 1'b0);
    alu_vec("sub_equal", 4'd1, 1'b1, 32'd3, 32'd3, 32'h0, 1'b1, 1'b0);
    alu_vec("sra", 4'd7, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1);
    alu_vec("srl", 4'd6, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0);
    alu_vec("sll_wrap_shamt", 4'd5, 1'b0, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0);
    alu_vec("add_overflow", 4'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0);
    alu_vec("slt", 4'd8, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    alu_vec("sltu", 4'd9, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    alu_vec("xor", 4'd4, 1'b0, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1'b1);
    alu_vec("pass", 4'd10, 1'b0, 32'hAAAA_AAAA, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b0);
    alu_vec("reserved_op", 4'd12, 1'b0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0);

    dec_vec("lbu", {7'b0, 3'b100, 7'b0000011}, 1'b0,
            dec(1, 0, 3'b001, 4'd0, 2'b00, 1, 0, 2'b00));
    dec_vec("lbu_nop", {7'b0, 3'b100, 7'b0000011}, 1'b1, '0);
    dec_vec("lh", {7'b0, 3'b001, 7'b0000011}, 1'b0,
            dec(1, 0, 3'b001, 4'd0, 2'b00, 1, 1, 2'b01));
    dec_vec("sub", {7'b0100000, 3'b000, 7'b0110011}, 1'b0,
            dec(1, 0, 3'b000, 4'd1, 2'b11, 0, 0, 2'b00));
    dec_vec("slt", {7'b0, 3'b010, 7'b0110011}, 1'b0,
            dec(1, 0, 3'b000, 4'd8, 2'b11, 0, 1, 2'b00));
    dec_vec("addi_f7b5", {7'b0100000, 3'b000, 7'b0010011}, 1'b0,
            dec(1, 0, 3'b000, 4'd0, 2'b00, 0, 0, 2'b00));
    dec_vec("srai", {7'b0100000, 3'b101, 7'b0010011}, 1'b0,
            dec(1, 0, 3'b000, 4'd7, 2'b00, 0, 0, 2'b00));
    dec_vec("sw", {7'b0, 3'b010, 7'b0100011}, 1'b0,
            dec(0, 1, 3'b000, 4'd0, 2'b01, 0, 0, 2'b10));
    dec_vec("bltu", {7'b0, 3'b110, 7'b1100011}, 1'b0,
            dec(0, 0, 3'b000, 4'd1, 2'b11, 0, 0, 2'b00));
    dec_vec("bge", {7'b0, 3'b101, 7'b1100011}, 1'b0,
            dec(0, 0, 3'b000, 4'd1, 2'b11, 0, 1, 2'b00));
    dec_vec("lui", {7'b0, 3'b000, 7'b0110111}, 1'b0,
            dec(1, 0, 3'b010, 4'd0, 2'b00, 0, 0, 2'b00));
    dec_vec("auipc", {7'b0, 3'b000, 7'b0010111}, 1'b0,
            dec(1, 0, 3'b100, 4'd0, 2'b00, 0, 0, 2'b00));
    dec_vec("jal", {7'b0, 3'b000, 7'b1101111}, 1'b0,
            dec(1, 0, 3'b011, 4'd0, 2'b10, 0, 0, 2'b00));
    dec_vec("jalr", {7'b0, 3'b000, 7'b1100111}, 1'b0,
            dec(1, 0, 3'b011, 4'd0, 2'b00, 0, 0, 2'b00));
    dec_vec("unknown_opcode", {7'b0, 3'b000, 7'b1111111}, 1'b0, '0);

    // Video region test first, while word 0 is still zero.
    mem_write("wr_8000_before", 32'h0000_8000, 32'h0000_0055, 1'b0, 32'h0);
`ifdef DMEM_VIDEO_GUARD_EN
    mem_read("video_guard_word0", 32'h0, 32'h0);
`else
    mem_read("no_guard_word0", 32'h0, 32'h0000_0055);
`endif

    mem_write("wr_40_before", 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
    mem_read("rd_40", 32'h40, 32'hDEAD_BEEF);
    mem_read("rd_43", 32'h43, 32'hDEAD_BEEF);
    mem_read("rd_1040_alias", 32'h1040, 32'hDEAD_BEEF);
    mem_write("wr_40_in_rst", 32'h40, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF);
    mem_read("rd_40_after_rst", 32'h40, 32'hDEAD_BEEF);
    mem_write("wr_1080_before", 32'h1080, 32'hCAFE_F00D, 1'b0, 32'h0);
    mem_read("rd_80_alias", 32'h80, 32'hCAFE_F00D);

    for (int unsigned i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
